// File: rtl/matmul_feeder.sv
// Streams two 4x4 byte matrices into memory, kicks the matmul engine, waits for
// completion with timeouts, then reads back and presents the pooled 2x2 result.
module matmul_feeder #(
  parameter logic [9:0]  A_BASE        = 10'h000,
  parameter logic [9:0]  B_BASE        = 10'h100,
  parameter logic [9:0]  C_BASE        = 10'h200,
  parameter int unsigned DONE_TIMEOUT  = 1024,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        mm_kick_start,
  input  logic        mm_ready,
  output logic        rd_en,
  output logic [9:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, KICK, WAIT_START, WAIT_DONE, READ, CAPT, OUT
  } state_t;

  localparam int unsigned TMAX = (DONE_TIMEOUT > START_TIMEOUT) ? DONE_TIMEOUT : START_TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d;
  logic          wr_en_q, wr_en_d;
  logic [9:0]    wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          kick_q, kick_d;
  logic [31:0]   res_data_q, res_data_d;
  logic          accept;

  // Gated by rstn so the input handshake is closed while reset is held.
  assign s_ready = rstn && (((state_q == IDLE) && mm_ready) || (state_q == LOAD));
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    err_d      = err_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    kick_d     = 1'b0;
    res_data_d = res_data_q;

    if (accept) begin
      cnt_d     = cnt_q + 3'd1;
      wr_en_d   = 1'b1;
      wr_addr_d = cnt_q[2] ? (B_BASE + {8'b0, cnt_q[1:0]}) : (A_BASE + {8'b0, cnt_q[1:0]});
      wr_data_d = s_data;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (accept && (cnt_q == 3'd7)) state_d = KICK;
      end
      // Kick is registered so it lands one cycle after the final B write.
      KICK: begin
        kick_d  = 1'b1;
        tmr_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (!mm_ready) begin
          tmr_d   = '0;
          state_d = WAIT_DONE;
        end else if (tmr_q == TW'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (mm_ready) begin
          state_d = READ;
        end else if (tmr_q == TW'(DONE_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      READ: state_d = CAPT;
      CAPT: begin
        res_data_d = rd_data;
        state_d    = OUT;
      end
      OUT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmr_q      <= '0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      kick_q     <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      kick_q     <= kick_d;
      res_data_q <= res_data_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign mm_kick_start = kick_q;
  assign rd_en         = (state_q == READ);
  assign rd_addr       = rd_en ? C_BASE : '0;
  assign res_valid     = (state_q == OUT);
  assign res_data      = res_data_q;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

endmodule
